// File: rtl/ahb_error_slave.sv
// ahb_error_slave: AHB default slave answering unmapped accesses with a two-cycle ERROR or an OKAY/RDATA_VAL reply.
// Ports: HCLK/HRESETn clock and async active-low reset; HSEL/HADDR/HTRANS/HWRITE/HREADY address phase in;
// HREADYOUT/HRESP/HRDATA data phase out; err_clr/err_count/err_addr/err_write error log.
// Define AHB_ERROR_SLAVE_ERRLOG_EN to build the error log; otherwise the log outputs are tied to 0.
module ahb_error_slave #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int WAIT_STATES = 0,
  parameter int RESP_MODE = 1,
  parameter logic [DATA_WIDTH-1:0] RDATA_VAL = 32'hDEAD_BEEF,
  parameter int ERRCNT_WIDTH = 16
) (
  input  logic                    HCLK,
  input  logic                    HRESETn,
  input  logic                    HSEL,
  input  logic [ADDR_WIDTH-1:0]   HADDR,
  input  logic [1:0]              HTRANS,
  input  logic                    HWRITE,
  input  logic                    HREADY,
  output logic                    HREADYOUT,
  output logic [1:0]              HRESP,
  output logic [DATA_WIDTH-1:0]   HRDATA,
  input  logic                    err_clr,
  output logic [ERRCNT_WIDTH-1:0] err_count,
  output logic [ADDR_WIDTH-1:0]   err_addr,
  output logic                    err_write
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP1, S_RESP2} state_t;
  localparam state_t AFTER_WAIT = RESP_MODE != 0 ? S_RESP1 : S_RESP2;
  localparam state_t FIRST = WAIT_STATES > 0 ? S_WAIT : AFTER_WAIT;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic ready_q;
  logic [1:0] resp_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic accept;
  // only IDLE and RESP2 present HREADYOUT=1, so address phases seen elsewhere are not real
  assign accept = HSEL & HREADY & HTRANS[1] & (state_q == S_IDLE || state_q == S_RESP2);
  assign state_d = state_q == S_WAIT  ? (cnt_q == 4'd0 ? AFTER_WAIT : S_WAIT) :
                   state_q == S_RESP1 ? S_RESP2 :
                   accept             ? FIRST : S_IDLE;
  assign cnt_d = state_q == S_WAIT ? cnt_q - 4'd1 : accept ? 4'(WAIT_STATES - 1) : cnt_q;
  // outputs are registered from the next state so they change exactly with the state
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      resp_q  <= 2'b00;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= state_d == S_IDLE || state_d == S_RESP2;
      resp_q  <= RESP_MODE != 0 && (state_d == S_RESP1 || state_d == S_RESP2) ? 2'b01 : 2'b00;
      rdata_q <= RESP_MODE == 0 && state_d == S_RESP2 ? RDATA_VAL : '0;
    end
  assign HREADYOUT = ready_q;
  assign HRESP     = resp_q;
  assign HRDATA    = rdata_q;
`ifdef AHB_ERROR_SLAVE_ERRLOG_EN
  logic [ERRCNT_WIDTH-1:0] err_count_q, err_count_d;
  logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d;
  logic err_write_q, err_write_d;
  logic inc;
  logic unused;
  assign inc = state_d == S_RESP2;
  // a clear on the same edge as a response leaves that response counted
  assign err_count_d = err_clr ? ERRCNT_WIDTH'(inc) : err_count_q + ERRCNT_WIDTH'(inc & ~&err_count_q);
  assign err_addr_d  = accept ? HADDR : err_clr ? '0 : err_addr_q;
  assign err_write_d = accept ? HWRITE : err_write_q & ~err_clr;
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      err_count_q <= '0;
      err_addr_q  <= '0;
      err_write_q <= 1'b0;
    end else begin
      err_count_q <= err_count_d;
      err_addr_q  <= err_addr_d;
      err_write_q <= err_write_d;
    end
  assign err_count = err_count_q;
  assign err_addr  = err_addr_q;
  assign err_write = err_write_q;
  assign unused    = HTRANS[0];
`else
  logic unused;
  assign err_count = '0;
  assign err_addr  = '0;
  assign err_write = 1'b0;
  assign unused    = ^{HTRANS[0], err_clr, HADDR, HWRITE};
`endif
endmodule

// File: tb/tb_ahb_error_slave.sv
// tb_ahb_error_slave: scoreboard bench for ahb_error_slave across four wait/response configurations.
module tb_ahb_error_slave;
`ifdef AHB_ERROR_SLAVE_ERRLOG_EN
  localparam bit LOG = 1'b1;
`else
  localparam bit LOG = 1'b0;
`endif
  localparam logic [34:0] IDLE_OUT = {1'b1, 2'b00, 32'h0};
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] sel = '0;
  logic [31:0] haddr = '0;
  logic [1:0] htrans = '0;
  logic hwrite = 1'b0;
  logic err_clr = 1'b0;
  logic rdy [4];
  logic [1:0] resp [4];
  logic [31:0] rdata [4];
  logic [15:0] ecnt [4];
  logic [31:0] eaddr [4];
  logic ewr [4];
  int act = 0;
  int passed = 0;
  int total = 0;
  logic [34:0] q [$];
  always #5 clk = ~clk;
  ahb_error_slave #(.WAIT_STATES(0), .RESP_MODE(1)) u0 (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(sel[0]), .HADDR(haddr), .HTRANS(htrans), .HWRITE(hwrite),
    .HREADY(rdy[0]), .HREADYOUT(rdy[0]), .HRESP(resp[0]), .HRDATA(rdata[0]),
    .err_clr(err_clr), .err_count(ecnt[0]), .err_addr(eaddr[0]), .err_write(ewr[0]));
  ahb_error_slave #(.WAIT_STATES(3), .RESP_MODE(1)) u1 (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(sel[1]), .HADDR(haddr), .HTRANS(htrans), .HWRITE(hwrite),
    .HREADY(rdy[1]), .HREADYOUT(rdy[1]), .HRESP(resp[1]), .HRDATA(rdata[1]),
    .err_clr(err_clr), .err_count(ecnt[1]), .err_addr(eaddr[1]), .err_write(ewr[1]));
  ahb_error_slave #(.WAIT_STATES(2), .RESP_MODE(0)) u2 (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(sel[2]), .HADDR(haddr), .HTRANS(htrans), .HWRITE(hwrite),
    .HREADY(rdy[2]), .HREADYOUT(rdy[2]), .HRESP(resp[2]), .HRDATA(rdata[2]),
    .err_clr(err_clr), .err_count(ecnt[2]), .err_addr(eaddr[2]), .err_write(ewr[2]));
  ahb_error_slave #(.WAIT_STATES(5), .RESP_MODE(1)) u3 (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(sel[3]), .HADDR(haddr), .HTRANS(htrans), .HWRITE(hwrite),
    .HREADY(rdy[3]), .HREADYOUT(rdy[3]), .HRESP(resp[3]), .HRDATA(rdata[3]),
    .err_clr(err_clr), .err_count(ecnt[3]), .err_addr(eaddr[3]), .err_write(ewr[3]));
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got === want) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, got, want);
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic expect_n(input logic r, input logic [1:0] s, input logic [31:0] d, input int n);
    repeat (n) q.push_back({r, s, d});
  endtask
  task automatic wait_rdy(input int k);
    for (int i = 0; i < 32 && rdy[k] !== 1'b1; i++) cyc();
  endtask
  task automatic present(input int k, input logic [31:0] a, input logic w);
    sel = '0;
    sel[k] = 1'b1;
    act = k;
    haddr = a;
    hwrite = w;
    htrans = 2'b10;
  endtask
  task automatic drop();
    sel = '0;
    htrans = 2'b00;
  endtask
  always @(negedge clk) begin
    logic [34:0] got;
    got = {rdy[act], resp[act], rdata[act]};
    if (rst_n === 1'b1 && got !== IDLE_OUT) begin
      if (q.size() == 0) chk("unexpected_response", got, IDLE_OUT);
      else chk("response", got, q.pop_front());
    end
  end
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    cyc();
    chk("rst_hreadyout", rdy[1], 1);
    chk("rst_hresp", resp[1], 0);
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("rst_hrdata", rdata[2], 0);
    chk("rst_err_count", ecnt[0], 0);
    chk("rst_err_addr", eaddr[0], 0);
    chk("rst_err_write", ewr[0], 0);
    // NONSEQ read, zero wait, ERROR reply
    expect_n(1'b0, 2'b01, 32'h0, 1);
    expect_n(1'b1, 2'b01, 32'h0, 1);
    present(0, 32'h4000_0010, 1'b0);
    cyc();
    drop();
    wait_rdy(0);
    cyc();
    chk("s1_err_addr", eaddr[0], LOG ? 32'h4000_0010 : 32'h0);
    chk("s1_err_write", ewr[0], 0);
    chk("s1_err_count", ecnt[0], LOG ? 16'd1 : 16'd0);
    // write with three wait states
    expect_n(1'b0, 2'b00, 32'h0, 3);
    expect_n(1'b0, 2'b01, 32'h0, 1);
    expect_n(1'b1, 2'b01, 32'h0, 1);
    present(1, 32'h4000_0020, 1'b1);
    cyc();
    drop();
    wait_rdy(1);
    cyc();
    chk("s2_err_write", ewr[1], LOG);
    chk("s2_err_addr", eaddr[1], LOG ? 32'h4000_0020 : 32'h0);
    // OKAY mode read with two wait states
    expect_n(1'b0, 2'b00, 32'h0, 2);
    expect_n(1'b1, 2'b00, 32'hDEAD_BEEF, 1);
    present(2, 32'h4000_0030, 1'b0);
    cyc();
    drop();
    wait_rdy(2);
    cyc();
    chk("s3_hrdata_after", rdata[2], 0);
    chk("s3_err_count", ecnt[2], LOG ? 16'd1 : 16'd0);
    // clear the log, then back-to-back transfers with the second accepted in RESP2
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    chk("clr_err_count", ecnt[0], 0);
    chk("clr_err_addr", eaddr[0], 0);
    expect_n(1'b0, 2'b01, 32'h0, 1);
    expect_n(1'b1, 2'b01, 32'h0, 1);
    expect_n(1'b0, 2'b01, 32'h0, 1);
    expect_n(1'b1, 2'b01, 32'h0, 1);
    present(0, 32'h4000_0100, 1'b0);
    cyc();
    haddr = 32'h4000_0200;
    hwrite = 1'b1;
    cyc();
    chk("b2b_resp2_ready", rdy[0], 1);
    cyc();
    drop();
    wait_rdy(0);
    cyc();
    chk("b2b_err_count", ecnt[0], LOG ? 16'd2 : 16'd0);
    chk("b2b_err_addr", eaddr[0], LOG ? 32'h4000_0200 : 32'h0);
    chk("b2b_err_write", ewr[0], LOG);
    // third completion with err_clr on the edge that enters RESP2
    expect_n(1'b0, 2'b01, 32'h0, 1);
    expect_n(1'b1, 2'b01, 32'h0, 1);
    present(0, 32'h4000_0300, 1'b0);
    cyc();
    drop();
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    cyc();
    chk("clr_inc_err_count", ecnt[0], LOG ? 16'd1 : 16'd0);
    chk("clr_inc_err_addr", eaddr[0], 0);
    chk("clr_inc_err_write", ewr[0], 0);
    // NONSEQ without HSEL is not a transfer
    act = 0;
    htrans = 2'b10;
    haddr = 32'h4000_0400;
    repeat (3) cyc();
    htrans = 2'b00;
    cyc();
    chk("nosel_err_count", ecnt[0], LOG ? 16'd1 : 16'd0);
    chk("nosel_err_addr", eaddr[0], 0);
    // reset asserted during the wait phase aborts the transfer
    expect_n(1'b0, 2'b00, 32'h0, 1);
    present(3, 32'h4000_0500, 1'b1);
    cyc();
    drop();
    cyc();
    chk("pre_rst_waiting", rdy[3], 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_hreadyout", rdy[3], 1);
    chk("mid_rst_hresp", resp[3], 0);
    cyc();
    rst_n = 1'b1;
    repeat (10) cyc();
    chk("post_rst_err_count", ecnt[3], 0);
    chk("post_rst_err_addr", eaddr[3], 0);
    chk("scoreboard_drained", q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
